// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into a byte-wide, big-endian instruction memory.
// Each accepted word becomes four consecutive byte writes, MSB first, at ascending addresses.
module imem_loader #(
  parameter int unsigned addresswidth = 32,
  parameter int unsigned width        = 8,
  parameter int unsigned depth        = 2**26,
  parameter int unsigned baseaddress  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    finish,
  input  logic [4*width-1:0]      wordIn,
  input  logic                    wordValid,
  output logic                    wordReady,
  output logic                    memWriteEnable,
  output logic [addresswidth-1:0] memAddress,
  output logic [width-1:0]        memDataIn,
  output logic [addresswidth-1:0] wordCount,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned WORDW = 4 * width;
  localparam logic [addresswidth-1:0] BASE    = addresswidth'(baseaddress);
  localparam logic [addresswidth-1:0] LAST_OK = addresswidth'(depth - 4);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              beat_q, beat_d;
  logic [WORDW-1:0]        shift_q, shift_d;
  logic [addresswidth-1:0] ptr_q, ptr_d;
  logic [addresswidth-1:0] count_q, count_d;
  logic                    pend_q, pend_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    we_q, we_d;
  logic [addresswidth-1:0] addr_q, addr_d;
  logic [width-1:0]        data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      ptr_q   <= BASE;
      count_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    pend_d  = pend_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      IDLE, DONE, ACCEPT: begin
        if (start) begin
          ptr_d   = BASE;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = ACCEPT;
        end else if (state_q == ACCEPT) begin
          if (wordValid) begin
            // A word that would cross depth-1 is dropped whole, never partially written
            if (ptr_q > LAST_OK) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              data_d  = wordIn[WORDW-1 -: width];
              shift_d = wordIn << width;
              beat_d  = 2'd1;
              pend_d  = finish;
              state_d = WRITE;
            end
          end else if (finish) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        pend_d = pend_q | finish;
        if (beat_q != 2'd0) begin
          we_d    = 1'b1;
          addr_d  = ptr_q + addresswidth'(beat_q);
          data_d  = shift_q[WORDW-1 -: width];
          shift_d = shift_q << width;
          beat_d  = beat_q + 2'd1;
        end else begin
          ptr_d   = ptr_q + addresswidth'(4);
          count_d = count_q + addresswidth'(1);
          if (pend_q | finish) begin
            done_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == ACCEPT);
    busy_d  = (state_d == ACCEPT) || (state_d == WRITE);
  end

  assign wordReady      = ready_q;
  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memDataIn      = data_q;
  assign wordCount      = count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule
